// File: rtl/enemy_collision.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : enemy_collision
// Description : Scans NUM_ENEMIES square enemy boxes against the live bullet,
//               one enemy per clock. Owns the per-enemy alive flags and the
//               saturating score, and pulses hit to retire the bullet.
//               Optional two-hit enemies: define ENEMY_COLLISION_HP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_collision #(
  parameter int NUM_ENEMIES = 4,
  parameter int ENEMY_SIZE  = 8,
  parameter int SCORE_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bullet_display,
  input  logic [6:0]               bullet_x,
  input  logic [6:0]               bullet_y,
  input  logic [7*NUM_ENEMIES-1:0] enemy_x,
  input  logic [7*NUM_ENEMIES-1:0] enemy_y,
  input  logic                     respawn,
  output logic                     hit,
  output logic [2:0]               hit_index,
  output logic [NUM_ENEMIES-1:0]   enemy_alive,
  output logic [SCORE_W-1:0]       score,
`ifdef ENEMY_COLLISION_HP_EN
  output logic [NUM_ENEMIES-1:0]   damaged,
`endif
  output logic                     all_cleared
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SCAN     = 2'd1;
  localparam logic [1:0] HIT      = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'(NUM_ENEMIES - 1);
  localparam logic [7:0] BOX      = 8'(ENEMY_SIZE);

  logic [1:0]             state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic                   hit_q, hit_d;
  logic [2:0]             hit_index_q, hit_index_d;
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   all_cleared_q, all_cleared_d;
  logic [NUM_ENEMIES-1:0] damaged_q, damaged_d;

  logic [6:0] sel_x, sel_y;
  logic       sel_alive;
  logic       match;
  logic       score_inc;

  // Select the enemy currently addressed by the scan index
  always_comb begin
    sel_x     = 7'd0;
    sel_y     = 7'd0;
    sel_alive = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (idx_q == 3'(i)) begin
        sel_x     = enemy_x[7*i +: 7];
        sel_y     = enemy_y[7*i +: 7];
        sel_alive = alive_q[i];
      end
    end
  end

  // Box test in 8 bits so a box near the right/bottom edge does not wrap
  always_comb begin
    match = sel_alive
          & ({1'b0, bullet_x} >= {1'b0, sel_x})
          & ({1'b0, bullet_x} <  ({1'b0, sel_x} + BOX))
          & ({1'b0, bullet_y} >= {1'b0, sel_y})
          & ({1'b0, bullet_y} <  ({1'b0, sel_y} + BOX));
  end

  // Scan FSM, kill bookkeeping and respawn override
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hit_index_d   = hit_index_q;
    alive_d       = alive_q;
    score_d       = score_q;
    damaged_d     = damaged_q;
    score_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bullet_display) begin
          state_d = SCAN;
          idx_d   = 3'd0;
        end
      end
      SCAN: begin
        if (!bullet_display) begin
          state_d = IDLE;
        end else if (match) begin
          hit_index_d = idx_q;
          state_d     = HIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      HIT: begin
        for (int i = 0; i < NUM_ENEMIES; i++) begin
          if (hit_index_q == 3'(i)) begin
`ifdef ENEMY_COLLISION_HP_EN
            if (damaged_q[i]) begin
              alive_d[i]   = 1'b0;
              damaged_d[i] = 1'b0;
              score_inc    = 1'b1;
            end else begin
              damaged_d[i] = 1'b1;
            end
`else
            alive_d[i] = 1'b0;
            score_inc  = 1'b1;
`endif
          end
        end
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        // One bullet may only ever score once; wait for it to retire.
        if (!bullet_display) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (score_inc && (score_q != {SCORE_W{1'b1}})) begin
      score_d = score_q + SCORE_W'(1);
    end

    // Respawn beats a same-cycle kill; the score still counts it.
    if (respawn) begin
      alive_d   = {NUM_ENEMIES{1'b1}};
      damaged_d = '0;
    end

    hit_d         = (state_d == HIT);
    all_cleared_d = (alive_q == '0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      hit_q         <= 1'b0;
      hit_index_q   <= 3'd0;
      alive_q       <= {NUM_ENEMIES{1'b1}};
      score_q       <= '0;
      all_cleared_q <= 1'b0;
      damaged_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hit_q         <= hit_d;
      hit_index_q   <= hit_index_d;
      alive_q       <= alive_d;
      score_q       <= score_d;
      all_cleared_q <= all_cleared_d;
      damaged_q     <= damaged_d;
    end
  end

  assign hit         = hit_q;
  assign hit_index   = hit_index_q;
  assign enemy_alive = alive_q;
  assign score       = score_q;
  assign all_cleared = all_cleared_q;
`ifdef ENEMY_COLLISION_HP_EN
  assign damaged     = damaged_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enemy_collision.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_enemy_collision
// Description : Directed self-checking bench for enemy_collision with an
//               expected-hit-index queue and a small alive/score model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_collision;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           bullet_display;
  logic [6:0]     bullet_x, bullet_y;
  logic [7*N-1:0] enemy_x, enemy_y;
  logic           respawn;
  logic           hit;
  logic [2:0]     hit_index;
  logic [N-1:0]   enemy_alive;
  logic [7:0]     score;
  logic           all_cleared;
`ifdef ENEMY_COLLISION_HP_EN
  logic [N-1:0]   damaged;
`endif

  enemy_collision #(.NUM_ENEMIES(N), .ENEMY_SIZE(8), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .bullet_display(bullet_display),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .respawn(respawn),
    .hit(hit), .hit_index(hit_index), .enemy_alive(enemy_alive),
    .score(score),
`ifdef ENEMY_COLLISION_HP_EN
    .damaged(damaged),
`endif
    .all_cleared(all_cleared)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic [N-1:0] m_alive;
  logic [7:0]   m_score;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shoot(input logic [6:0] x, input logic [6:0] y, input int idx, input bit expect_hit);
    bullet_x       = x;
    bullet_y       = y;
    bullet_display = 1'b1;
    if (expect_hit) exp_q.push_back(3'(idx));
  endtask

  // Wait (bounded) for the hit pulse, then score it against the queue head.
  task automatic await_hit(input string tag);
    int         n = 0;
    logic [2:0] e;
    while (hit !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_hit"}, 32'(hit), 32'd1);
    check({tag, "_latency"}, 32'(n <= N + 2), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, 32'(hit_index), 32'(e));
      m_alive[e] = 1'b0;
      if (m_score != 8'hFF) m_score = m_score + 8'd1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_alive"}, 32'(enemy_alive), 32'(m_alive));
    check({tag, "_score"}, 32'(score), 32'(m_score));
  endtask

  task automatic drop();
    bullet_display = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_respawn();
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    m_alive = '1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    reset          = 1'b1;
    bullet_display = 1'b0;
    bullet_x       = 7'd0;
    bullet_y       = 7'd0;
    respawn        = 1'b0;
    // enemy3 (7C,0), enemy2 (50,10), enemy1 (30,10), enemy0 (10,10)
    enemy_x = {7'h7C, 7'd50, 7'd30, 7'd10};
    enemy_y = {7'd0,  7'd10, 7'd10, 7'd10};
    m_alive = '1;
    m_score = 8'd0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_index", 32'(hit_index), 32'd0);
    check("rst_cleared", 32'(all_cleared), 32'd0);
    check_model("rst");

`ifdef ENEMY_COLLISION_HP_EN
    shoot(7'd31, 7'd11, 1, 1'b1);
    await_hit("hp1");
    tick();
    check("hp1_damaged", 32'(damaged), 32'h2);
    check("hp1_alive", 32'(enemy_alive), 32'hF);
    check("hp1_score", 32'(score), 32'd0);
    drop();
    shoot(7'd31, 7'd11, 1, 1'b1);
    await_hit("hp2");
    tick();
    check("hp2_damaged", 32'(damaged), 32'h0);
    check("hp2_alive", 32'(enemy_alive), 32'hD);
    check("hp2_score", 32'(score), 32'd1);
    drop();
`else
    // First kill on enemy0
    shoot(7'd12, 7'd13, 0, 1'b1);
    await_hit("t1");
    tick();
    check_model("t1");

    // Bullet lingers: no second pulse
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hit === 1'b1) hits++;
    end
    check("t2_extra_hits", 32'(hits), 32'd0);
    drop();
    check_model("t2");

    // Exclusive right edge: x=18 is outside [10,18)
    do_respawn();
    check_model("t3_respawn");
    shoot(7'd18, 7'd10, 0, 1'b0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (hit === 1'b1) hits++;
    end
    check("t3_edge_hits", 32'(hits), 32'd0);
    drop();

    // Box near the far edge must not wrap
    shoot(7'h7E, 7'd2, 3, 1'b1);
    await_hit("t3_nowrap");
    tick();
    check_model("t3_nowrap");
    drop();

    // Inclusive far corner of enemy0
    shoot(7'd17, 7'd17, 0, 1'b1);
    await_hit("t3_corner");
    tick();
    check_model("t3_corner");
    drop();

    // Clear the rest
    shoot(7'd31, 7'd11, 1, 1'b1);
    await_hit("t4_e1");
    tick();
    check_model("t4_e1");
    drop();
    shoot(7'd57, 7'd17, 2, 1'b1);
    await_hit("t4_e2");
    tick();
    check_model("t4_e2");
    check("t4_cleared_lag", 32'(all_cleared), 32'd0);
    tick();
    check("t4_cleared", 32'(all_cleared), 32'd1);
    drop();
    do_respawn();
    check_model("t4_respawn");
    tick();
    check("t4_uncleared", 32'(all_cleared), 32'd0);

    // Drive the score to saturation
    while (m_score != 8'hFF) begin
      shoot(7'd12, 7'd13, 0, 1'b1);
      await_hit("t5_fill");
      tick();
      drop();
      do_respawn();
    end
    check_model("t5_full");

    // Kill with respawn in the HIT cycle: respawn wins, score stays saturated
    shoot(7'd12, 7'd13, 0, 1'b1);
    await_hit("t5_sat");
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    m_alive = '1;
    check_model("t5_sat");
    drop();

    // Reset during the HIT cycle: no kill lands, everything returns to reset
    shoot(7'd31, 7'd11, 1, 1'b1);
    await_hit("t7");
    reset          = 1'b1;
    bullet_display = 1'b0;
    tick();
    reset   = 1'b0;
    m_alive = '1;
    m_score = 8'd0;
    check("t7_hit", 32'(hit), 32'd0);
    check("t7_hit_index", 32'(hit_index), 32'd0);
    check_model("t7");
    tick();
    check("t7_hit_after", 32'(hit), 32'd0);
    check_model("t7_after");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
